// File: rtl/v_shift_deserializer_pkg.sv
`default_nettype none
// ============================================================================
// v_shift_deserializer_pkg : state encoding and counter sizing helper
// Revision 1.0
// ============================================================================
package v_shift_deserializer_pkg;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  // Bits needed to hold a count in 0..value-1.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage : v_shift_deserializer_pkg
`default_nettype wire

// File: rtl/v_shift_deser_ctrl.sv
`default_nettype none
// ============================================================================
// v_shift_deser_ctrl : frame state machine and bit counter
// Revision 1.0
// ============================================================================
module v_shift_deser_ctrl
  import v_shift_deserializer_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_se,
  input  logic i_sof,
  output logic o_load,
  output logic o_shift,
  output logic o_complete,
  output logic o_ferr_set
);

  localparam int CW = clog2(WIDTH);

  state_t          r_state, w_state_nxt;
  logic [CW-1:0]   r_cnt, w_cnt_nxt;
  logic            w_last;

  assign w_last = (r_cnt == CW'(WIDTH - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    o_load      = 1'b0;
    o_shift     = 1'b0;
    o_complete  = 1'b0;
    o_ferr_set  = 1'b0;
    if (i_se) begin
      if (i_sof) begin
        // SOF always restarts; only a partially filled word is a framing error
        o_load      = 1'b1;
        w_state_nxt = ST_SHIFT;
        w_cnt_nxt   = CW'(1);
        o_ferr_set  = (r_state == ST_SHIFT) && (r_cnt != '0);
      end else if (r_state == ST_SHIFT) begin
        o_shift = 1'b1;
        if (w_last) begin
          o_complete = 1'b1;
          w_cnt_nxt  = '0;
        end else begin
          w_cnt_nxt  = r_cnt + CW'(1);
        end
      end
    end
  end

endmodule : v_shift_deser_ctrl
`default_nettype wire

// File: rtl/v_shift_deserializer.sv
`default_nettype none
// ============================================================================
// v_shift_deserializer : MSB-first serial-to-parallel with holding register,
//                        ready handshake and sticky overrun/framing flags
// Revision 1.0
// ============================================================================
module v_shift_deserializer
  import v_shift_deserializer_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             C,
  input  logic             CLR_N,
  input  logic             SI,
  input  logic             SE,
  input  logic             SOF,
  output logic [WIDTH-1:0] DO,
  output logic             DV,
  input  logic             DR,
  output logic             OVF,
  output logic             FERR,
  input  logic             ERR_CLR
);

  // The MSB is never kept: a full word always leaves via w_word on the last edge.
  logic [WIDTH-2:0] r_sr;
  logic [WIDTH-1:0] r_do;
  logic             r_dv;
  logic             r_ovf;
  logic             r_ferr;
  logic [WIDTH-1:0] w_word;
  logic             w_load;
  logic             w_shift;
  logic             w_complete;
  logic             w_ferr_set;
  logic             w_ovf_set;

  v_shift_deser_ctrl #(
    .WIDTH (WIDTH)
  ) u_ctrl (
    .clk        (C),
    .rst_n      (CLR_N),
    .i_se       (SE),
    .i_sof      (SOF),
    .o_load     (w_load),
    .o_shift    (w_shift),
    .o_complete (w_complete),
    .o_ferr_set (w_ferr_set)
  );

  assign w_word    = {r_sr, SI};
  assign w_ovf_set = w_complete && r_dv && !DR;

  always_ff @(posedge C or negedge CLR_N) begin
    if (!CLR_N) begin
      r_sr   <= '0;
      r_do   <= '0;
      r_dv   <= 1'b0;
      r_ovf  <= 1'b0;
      r_ferr <= 1'b0;
    end else begin
      if (w_load) begin
        r_sr    <= '0;
        r_sr[0] <= SI;
      end else if (w_shift) begin
        r_sr <= w_word[WIDTH-2:0];
      end

      if (w_complete && (!r_dv || DR)) begin
        r_do <= w_word;
        r_dv <= 1'b1;
      end else if (r_dv && DR && !w_complete) begin
        r_dv <= 1'b0;
      end

      if (w_ovf_set)    r_ovf <= 1'b1;
      else if (ERR_CLR) r_ovf <= 1'b0;

      if (w_ferr_set)   r_ferr <= 1'b1;
      else if (ERR_CLR) r_ferr <= 1'b0;
    end
  end

  assign DO   = r_do;
  assign DV   = r_dv;
  assign OVF  = r_ovf;
  assign FERR = r_ferr;

endmodule : v_shift_deserializer
`default_nettype wire

// File: tb/tb_v_shift_deserializer.sv
`default_nettype none
// ============================================================================
// tb_v_shift_deserializer : directed scenarios checked against a word-level
//                           model every cycle, plus literal spot checks
// Revision 1.0
// ============================================================================
module tb_v_shift_deserializer;

  localparam int W = 8;

  logic         C = 1'b0;
  logic         CLR_N = 1'b0;
  logic         SI = 1'b0, SE = 1'b0, SOF = 1'b0, DR = 1'b0, ERR_CLR = 1'b0;
  logic [W-1:0] DO;
  logic         DV, OVF, FERR;

  int n_vec = 0;
  int n_err = 0;

  v_shift_deserializer #(.WIDTH(W)) dut (
    .C(C), .CLR_N(CLR_N), .SI(SI), .SE(SE), .SOF(SOF),
    .DO(DO), .DV(DV), .DR(DR), .OVF(OVF), .FERR(FERR), .ERR_CLR(ERR_CLR)
  );

  always #5 C = ~C;

  // Word-level model: bits accumulate arithmetically into an integer.
  bit           m_in_frame;
  int           m_nbits, m_acc;
  logic [W-1:0] m_do, m_word;
  bit           m_dv, m_ovf, m_ferr, m_emit, m_fs, m_os;

  always @(posedge C) begin
    if (!CLR_N) begin
      m_in_frame = 0; m_nbits = 0; m_acc = 0;
      m_do = '0; m_dv = 0; m_ovf = 0; m_ferr = 0;
    end else begin
      m_emit = 0; m_fs = 0; m_os = 0; m_word = '0;
      if (SE) begin
        if (SOF) begin
          if (m_in_frame && m_nbits != 0) m_fs = 1;
          m_in_frame = 1; m_acc = int'(SI); m_nbits = 1;
        end else if (m_in_frame) begin
          m_acc = m_acc * 2 + int'(SI);
          m_nbits++;
          if (m_nbits == W) begin
            m_emit = 1; m_word = m_acc[W-1:0]; m_nbits = 0; m_acc = 0;
          end
        end
      end
      if (m_emit) begin
        if (!m_dv || DR) begin m_do = m_word; m_dv = 1; end
        else m_os = 1;
      end else if (m_dv && DR) begin
        m_dv = 0;
      end
      if (ERR_CLR) begin m_ovf = 0; m_ferr = 0; end
      if (m_os) m_ovf = 1;
      if (m_fs) m_ferr = 1;
    end
    #1;
    n_vec++;
    if (DO !== m_do || DV !== m_dv || OVF !== m_ovf || FERR !== m_ferr) begin
      n_err++;
      $display("FAIL model t=%0t: DO=%h DV=%b OVF=%b FERR=%b, expected DO=%h DV=%b OVF=%b FERR=%b",
               $time, DO, DV, OVF, FERR, m_do, m_dv, m_ovf, m_ferr);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic se, input logic si, input logic sof,
                       input logic dr, input logic ec);
    @(negedge C);
    SE = se; SI = si; SOF = sof; DR = dr; ERR_CLR = ec;
  endtask

  task automatic idle(input logic dr);
    drive(1'b0, 1'b0, 1'b0, dr, 1'b0);
  endtask

  // nb bits of w, MSB first; the last bit carries its own DR/ERR_CLR values.
  task automatic send(input logic [W-1:0] w, input int nb, input logic sof,
                      input logic dr, input logic dr_last, input logic ec_last);
    for (int i = W - 1; i >= W - nb; i--) begin
      if (i == W - nb) drive(1'b1, w[i], sof && (i == W - 1), dr_last, ec_last);
      else             drive(1'b1, w[i], sof && (i == W - 1), dr, 1'b0);
    end
  endtask

  initial begin
    // Reset state
    repeat (2) @(negedge C);
    check("reset DO", 32'(DO), 32'h0);
    check("reset DV", 32'(DV), 32'h0);
    check("reset OVF/FERR", {30'd0, OVF, FERR}, 32'h0);
    CLR_N = 1'b1;

    // B2 with DR=1: DV for exactly one cycle after the 8th edge
    send(8'hB2, 8, 1'b1, 1'b1, 1'b1, 1'b0);
    idle(1'b1);
    check("B2 DO", 32'(DO), 32'hB2);
    check("B2 DV high", 32'(DV), 32'h1);
    idle(1'b1);
    check("B2 DV low", 32'(DV), 32'h0);

    // Back-to-back A5, 3C with DR=0: overrun, 3C discarded
    send(8'hA5, 8, 1'b1, 1'b0, 1'b0, 1'b0);
    send(8'h3C, 8, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(1'b0);
    check("ovr DO", 32'(DO), 32'hA5);
    check("ovr DV/OVF", {30'd0, DV, OVF}, 32'h3);
    idle(1'b1);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    idle(1'b0);
    check("ovr cleared", 32'(OVF), 32'h0);

    // Overrun on the same edge as ERR_CLR: set wins
    send(8'h11, 8, 1'b0, 1'b0, 1'b0, 1'b0);
    send(8'h22, 8, 1'b0, 1'b0, 1'b0, 1'b1);
    idle(1'b0);
    check("ovr set wins", 32'(OVF), 32'h1);
    check("ovr set wins DO", 32'(DO), 32'h11);
    idle(1'b1);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

    // SOF mid-word at CNT=3, then FF
    send(8'hA0, 3, 1'b1, 1'b1, 1'b1, 1'b0);
    send(8'hFF, 8, 1'b1, 1'b0, 1'b0, 1'b0);
    idle(1'b0);
    check("ferr FERR", 32'(FERR), 32'h1);
    check("ferr DO", 32'(DO), 32'hFF);
    check("ferr DV", 32'(DV), 32'h1);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    idle(1'b0);
    check("ferr cleared", 32'(FERR), 32'h0);

    // 5A with SE toggled, DR=1
    for (int i = W - 1; i >= 0; i--) begin
      drive(1'b1, 8'h5A >> i, i == W - 1, 1'b1, 1'b0);
      if (i == 0) begin
        drive(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        check("5A DV after 8th", 32'(DV), 32'h1);
        check("5A DO", 32'(DO), 32'h5A);
      end else begin
        drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        if (i == 1) check("5A DV before 8th", 32'(DV), 32'h0);
      end
    end
    idle(1'b1);

    // Reset mid-word, then 81 without SOF (ignored), then with SOF
    send(8'hFF, 5, 1'b1, 1'b0, 1'b0, 1'b0);
    @(negedge C); CLR_N = 1'b0; SE = 1'b0;
    @(negedge C); CLR_N = 1'b1;
    send(8'h81, 8, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(1'b0);
    check("no-SOF DV", 32'(DV), 32'h0);
    send(8'h81, 8, 1'b1, 1'b0, 1'b0, 1'b0);
    idle(1'b0);
    check("81 DO/DV", {23'd0, DV, DO}, {23'd0, 1'b1, 8'h81});

    // Consume coinciding with completion of 0F (SOF realigns at CNT=0)
    send(8'h0F, 8, 1'b1, 1'b0, 1'b1, 1'b0);
    idle(1'b0);
    check("0F DO", 32'(DO), 32'h0F);
    check("0F DV/OVF/FERR", {29'd0, DV, OVF, FERR}, 32'h4);
    idle(1'b1);
    idle(1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_v_shift_deserializer
`default_nettype wire

// File: doc/v_shift_deserializer.md
V_SHIFT_DESERIALIZER -- requirements
Module: v_shift_deserializer

Interface
REQ-001 Parameter: WIDTH, default 8, word length in bits; legal range 2..32.
REQ-002 Port: C  input  1  clock; all state changes on rising edge.
REQ-003 Port: CLR_N  input  1  reset, asynchronous, active-low.
REQ-004 Port: SI  input  1  serial data in, MSB first.
REQ-005 Port: SE  input  1  serial enable; SI sampled only on edges where SE=1.
REQ-006 Port: SOF  input  1  start-of-frame; qualified by SE; marks the sampled bit as word bit WIDTH-1 (MSB).
REQ-007 Port: DO  output  WIDTH  received parallel word (holding register).
REQ-008 Port: DV  output  1  DO valid.
REQ-009 Port: DR  input  1  consumer ready; a word transfers on an edge with DV=1 and DR=1.
REQ-010 Port: OVF  output  1  sticky overrun flag.
REQ-011 Port: FERR  output  1  sticky framing-error flag.
REQ-012 Port: ERR_CLR  input  1  synchronous clear of OVF and FERR.

Function
REQ-013 States: IDLE (no frame), SHIFT (collecting); bit counter CNT, range 0..WIDTH-1.
REQ-014 IDLE: SE=1 with SOF=0 is ignored; SE=1 with SOF=1 shifts SI in, sets CNT=1, enters SHIFT.
REQ-015 SHIFT, SE=1, SOF=0: shift register <= {sr[WIDTH-2:0], SI}; CNT increments.
REQ-016 SHIFT, SE=0: shift register, CNT and state hold; no timeout.
REQ-017 Word completion: edge with SE=1 and CNT=WIDTH-1 (SOF=0) yields word {sr[WIDTH-2:0], SI}; CNT wraps to 0; state stays SHIFT (back-to-back words need no new SOF).
REQ-018 On completion with DV=0, or DV=1 and DR=1 on the same edge: DO <= completed word, DV=1 after that edge (zero-cycle latency from last bit edge to DV).
REQ-019 On completion with DV=1 and DR=0: completed word discarded, DO and DV unchanged, OVF <= 1.
REQ-020 Edge with DV=1, DR=1 and no completion: DV <= 0; DO holds its value.
REQ-021 SOF=1 with SE=1 in SHIFT and CNT!=0: partial word discarded, FERR <= 1, SI taken as new MSB, CNT=1.
REQ-022 SOF=1 with SE=1 in SHIFT and CNT=0: legal realignment, no FERR, CNT=1.
REQ-023 WIDTH-bit word where SOF coincides with bit 0 (CNT=WIDTH-1): treated as REQ-021; no word is emitted.
REQ-024 ERR_CLR=1 clears OVF and FERR; if a set condition occurs on the same edge, the set wins.
REQ-025 DV and DO are independent of SE, SI once loaded; DR is ignored when DV=0.

Reset
REQ-026 CLR_N=0 asynchronously forces: state IDLE, CNT=0, shift register=0, DO=0, DV=0, OVF=0, FERR=0.
REQ-027 Reset mid-word discards the partial word; after release, first accepted bit requires SOF.
REQ-028 Reset release is synchronised externally; no internal reset synchroniser.

Structure
REQ-029 Shared package holds state encoding (IDLE, SHIFT) and the CNT width function clog2(WIDTH).
REQ-030 One sub-module, v_shift_deser_ctrl: state machine and bit counter; datapath (shift/holding registers, flags) stays in the top.
REQ-031 All registers in the single clock domain C; no latches, no combinational paths from inputs to outputs.

Verification
REQ-032 WIDTH=8, SOF on first bit, serial 1,0,1,1,0,0,1,0 with SE=1, DR=1 -> DO=8'hB2, DV=1 exactly one cycle after edge 8, then DV=0.
REQ-033 Two back-to-back words 8'hA5, 8'h3C, DR=0 throughout -> DO=8'hA5, DV=1, OVF=1 at edge 16, 8'h3C never visible.
REQ-034 SOF mid-word at CNT=3, then 8 bits of 8'hFF -> FERR=1, DO=8'hFF, DV=1; ERR_CLR pulse -> FERR=0.
REQ-035 SE toggled 0/1 every other cycle while sending 8'h5A, DR=1 -> DO=8'h5A; DV rises only after 8th enabled edge.
REQ-036 CLR_N low after 5 bits, release, send 8'h81 without SOF then with SOF -> first attempt no DV; second DO=8'h81.
REQ-037 DV=1, DR=1 on same edge as next completion (8'h0F) -> DV stays 1, DO=8'h0F, OVF=0.
